// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, data width and arbiter state encoding
package alu_pkg;
  localparam int DATA_W = 32;
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR = 5'b00110;
  localparam logic [4:0] OP_XOR = 5'b00111;
  localparam logic [4:0] OP_WORD = 5'b10100;
  localparam logic [4:0] OP_IDLE = 5'b11111;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: circular first-set search starting at ptr, one-hot grant plus index
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU with registered operands and tagged responses
module alu_share_arbiter import alu_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int SEL_W = 5,
  parameter logic [SEL_W-1:0] IDLE_SEL = OP_IDLE,
  parameter int TIMEOUT = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_zero,
  output logic                      resp_err,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [SEL_W-1:0]          alu_sel,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_complete,
  output logic                      busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, gidx;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic zero_q, zero_d, err_q, err_d;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(req_valid),
    .ptr(ptr_q),
    .grant(grant),
    .idx(gidx)
  );
  assign req_ready = (state_q == ST_IDLE && !reset) ? grant : '0;
  assign resp_valid = state_q == ST_RESP;
  assign busy = state_q != ST_IDLE;
  assign resp_id = id_q;
  assign resp_data = data_q;
  assign resp_zero = zero_q;
  assign resp_err = err_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_sel = sel_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    data_d = data_q;
    zero_d = zero_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: if (|req_valid) begin
        id_d = gidx;
        a_d = req_a[gidx*DATA_W +: DATA_W];
        b_d = req_b[gidx*DATA_W +: DATA_W];
        sel_d = req_sel[gidx*SEL_W +: SEL_W];
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (alu_complete) begin
          data_d = alu_out;
          zero_d = alu_out == '0;
          err_d = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          data_d = '1;
          zero_d = 1'b0;
          err_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (resp_ready) begin
        sel_d = IDLE_SEL;
        ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sel_q <= IDLE_SEL;
      cnt_q <= '0;
      data_q <= '0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      zero_q <= zero_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: vector table, corner sequences and random traffic against a behavioural ALU and arbiter model
module tb_alu_share_arbiter;
  import alu_pkg::*;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 4;
  localparam int ID_W = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*32-1:0] req_a = '0;
  logic [NUM_REQ*32-1:0] req_b = '0;
  logic [NUM_REQ*5-1:0] req_sel = '0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic [ID_W-1:0] resp_id;
  logic [31:0] resp_data;
  logic resp_zero, resp_err;
  logic [31:0] alu_a, alu_b;
  logic [4:0] alu_sel;
  logic [31:0] alu_out = '0;
  logic alu_complete = 1'b0;
  logic busy;
  int alu_lat = 0;
  int lat_cnt = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    int idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] sel;
    int lat;
    int dly;
    logic [31:0] d;
    logic z;
    logic e;
  } vec_t;
  vec_t tv[8];
  logic [NUM_REQ-1:0] pv;
  logic [31:0] pa[NUM_REQ], pb[NUM_REQ];
  logic [4:0] ps[NUM_REQ];
  logic [4:0] ops[7] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR};
  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(32), .SEL_W(5), .IDLE_SEL(5'b11111), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_complete(alu_complete), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    case (s)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_MUL: return a * b;
      OP_DIV: return a / b;
      OP_AND: return a & b;
      OP_OR: return a | b;
      OP_XOR: return a ^ b;
      default: return 32'h0;
    endcase
  endfunction
  always @(posedge clk) begin
    if (alu_sel == 5'b11111) begin
      alu_complete <= 1'b0;
      lat_cnt <= 0;
    end else if (!alu_complete && !(alu_sel == OP_DIV && alu_b == 0)) begin
      if (lat_cnt >= alu_lat) begin
        alu_out <= ref_op(alu_a, alu_b, alu_sel);
        alu_complete <= 1'b1;
      end else lat_cnt <= lat_cnt + 1;
    end
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s, input logic v);
    req_valid[i] = v;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_sel[i*5 +: 5] = s;
  endtask
  task automatic reset_dut();
    @(negedge clk);
    req_valid = '0;
    resp_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask
  task automatic wait_resp(input int idx, input int el);
    int k;
    logic stray;
    @(negedge clk);
    req_valid[idx] = 1'b0;
    #1;
    k = 1;
    stray = 1'b0;
    while (!resp_valid && k < 20) begin
      if (req_ready != '0) stray = 1'b1;
      @(negedge clk);
      #1;
      k++;
    end
    chk("resp_latency", k, el);
    chk("no_grant_while_busy", stray, 0);
  endtask
  task automatic finish_resp(input int id, input logic [31:0] ed, input logic ez, input logic ee, input int dly);
    logic st;
    chk("resp_id", resp_id, id);
    chk("resp_data", resp_data, ed);
    chk("resp_zero", resp_zero, ez);
    chk("resp_err", resp_err, ee);
    st = 1'b1;
    repeat (dly) begin
      @(negedge clk);
      #1;
      if (resp_valid !== 1'b1 || resp_data !== ed || resp_id !== ID_W'(id) || resp_zero !== ez || resp_err !== ee || req_ready !== '0) st = 1'b0;
    end
    chk("resp_hold", st, 1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("resp_drop", {resp_valid, busy}, 0);
  endtask
  task automatic do_txn(input vec_t v);
    int n;
    logic [NUM_REQ-1:0] er;
    er = '0;
    er[v.idx] = 1'b1;
    alu_lat = v.lat;
    drive(v.idx, v.a, v.b, v.sel, 1'b1);
    #1;
    n = 0;
    while (req_ready == '0 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant", req_ready, er);
    wait_resp(v.idx, v.e ? 2 + TIMEOUT : 3 + v.lat);
    finish_resp(v.idx, v.d, v.z, v.e, v.dly);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int got, last, cyc, w, lat;
    logic sp;
    logic to;
    logic [31:0] ed;
    logic [NUM_REQ-1:0] er;
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    tv[0] = '{0, 32'd5, 32'd7, OP_ADD, 0, 0, 32'd12, 1'b0, 1'b0};
    tv[1] = '{2, 32'd9, 32'd9, OP_SUB, 0, 0, 32'd0, 1'b1, 1'b0};
    tv[2] = '{1, 32'd10, 32'd0, OP_DIV, 0, 0, 32'hFFFFFFFF, 1'b0, 1'b1};
    tv[3] = '{3, 32'd1, 32'd1, OP_ADD, 0, 0, 32'd2, 1'b0, 1'b0};
    tv[4] = '{1, 32'd6, 32'd7, OP_MUL, 2, 2, 32'd42, 1'b0, 1'b0};
    tv[5] = '{0, 32'd100, 32'd4, OP_DIV, 3, 0, 32'd25, 1'b0, 1'b0};
    tv[6] = '{2, 32'd3, 32'd3, OP_ADD, 4, 1, 32'hFFFFFFFF, 1'b0, 1'b1};
    tv[7] = '{3, 32'hF0F0F0F0, 32'h0F0F0F0F, OP_AND, 0, 0, 32'd0, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    req_valid[0] = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_flags", {resp_zero, resp_err}, 0);
    chk("rst_alu_ab", {alu_a, alu_b}, 0);
    chk("rst_alu_sel", alu_sel, 5'b11111);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    #1;
    for (int i = 0; i < 8; i++) do_txn(tv[i]);
    reset_dut();
    resp_ready = 1'b1;
    alu_lat = 0;
    for (int i = 0; i < NUM_REQ; i++) drive(i, i + 1, 32'd10, OP_ADD, 1'b1);
    #1;
    got = 0;
    last = -1;
    cyc = 0;
    sp = 1'b1;
    while (got < 5 && cyc < 60) begin
      if (req_ready != '0) begin
        er = '0;
        er[rr_exp[got]] = 1'b1;
        chk("rr_order", req_ready, er);
        if (last >= 0 && cyc - last != 4) sp = 1'b0;
        last = cyc;
        got++;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("rr_count", got, 5);
    chk("rr_spacing", sp, 1);
    reset_dut();
    alu_lat = 0;
    drive(1, 32'd20, 32'd22, OP_ADD, 1'b1);
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    drive(3, 32'd7, 32'd8, OP_XOR, 1'b1);
    #1;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("bp_latency", cyc, 3);
    finish_resp(1, 32'd42, 1'b0, 1'b0, 5);
    chk("bp_next_grant", req_ready, 4'b1000);
    wait_resp(3, 3);
    finish_resp(3, 32'd15, 1'b0, 1'b0, 0);
    alu_lat = 3;
    drive(0, 32'd6, 32'd7, OP_MUL, 1'b1);
    #1;
    chk("rw_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("rw_in_wait", {busy, resp_valid}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_alu_sel", alu_sel, 5'b11111);
    sp = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (resp_valid !== 1'b0) sp = 1'b0;
    end
    chk("rw_lost", sp, 1);
    do_txn('{2, 32'd1, 32'd1, OP_ADD, 0, 0, 32'd2, 1'b0, 1'b0});
    reset_dut();
    pv = '0;
    w = 0;
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i] = 1'b1;
          ps[i] = ops[$urandom_range(6, 0)];
          pa[i] = ($urandom_range(1, 0) == 1) ? $urandom : 32'($urandom_range(20, 0));
          pb[i] = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
          if ($urandom_range(4, 0) == 0) pb[i] = pa[i];
        end
      end
      if (pv == '0) begin
        w = $urandom_range(NUM_REQ - 1, 0);
        pv[w] = 1'b1;
        ps[w] = OP_ADD;
        pa[w] = $urandom;
        pb[w] = $urandom;
      end
      for (int i = 0; i < NUM_REQ; i++) drive(i, pa[i], pb[i], ps[i], pv[i]);
      lat = $urandom_range(5, 0);
      alu_lat = lat;
      #1;
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) if (w < 0 && pv[(last + 1 + k) % NUM_REQ]) w = (last + 1 + k) % NUM_REQ;
      er = '0;
      er[w] = 1'b1;
      chk("rand_grant", req_ready, er);
      to = (ps[w] == OP_DIV && pb[w] == 0) || lat >= TIMEOUT;
      ed = to ? 32'hFFFFFFFF : ref_op(pa[w], pb[w], ps[w]);
      pv[w] = 1'b0;
      wait_resp(w, to ? 2 + TIMEOUT : 3 + lat);
      finish_resp(w, ed, ed == 0, to, $urandom_range(3, 0));
      last = w;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one PE ALU among NUM_REQ requesters: the PE decode stage plus neighbour CGRA links.
- Arbitrates round-robin and holds the winner's operands stable on the ALU inputs.
- Sequences the ALU's idle/complete protocol and returns a tagged response with zero and error flags.
- Sits between the requesters and the ALU inside the PE; it is the only driver of the ALU operand and select inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width
SEL_W, 5, ALU select width
IDLE_SEL, 5'b11111, ALU idle opcode; the ALU clears its complete flag while it executes this opcode
TIMEOUT, 4, WAIT cycles without completion before error

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  one-hot accept pulse
req_a  in  NUM_REQ*DATA_W  operand A, packed, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand B, packed
req_sel  in  NUM_REQ*SEL_W  ALU opcode, packed
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_id  out  $clog2(NUM_REQ)  index of the requester that owns the response
resp_data  out  DATA_W  result
resp_zero  out  1  resp_data == 0
resp_err  out  1  timeout or divide-by-zero
alu_a, alu_b  out  DATA_W each  ALU operands
alu_sel  out  SEL_W  ALU opcode
alu_out  in  DATA_W  ALU result (registered)
alu_complete  in  1  ALU completion flag (registered, sticky until IDLE_SEL executes)
busy  out  1  state != IDLE

Behaviour:
Reset values:
- state IDLE; rr pointer 0.
- req_ready 0, resp_valid 0, resp_id 0, resp_data 0, resp_zero 0, resp_err 0.
- alu_a 0, alu_b 0, alu_sel IDLE_SEL; busy 0.

Operand path:
- alu_a, alu_b and alu_sel come from registers; there is no combinational path from req_* to the ALU.
- The ALU's own Zero output lags by one operation, so it is not used; resp_zero is computed internally from the captured result.

IDLE:
- alu_sel = IDLE_SEL.
- If any req_valid is set, grant the first set bit at or after the rr pointer, searching circularly.
- In the same cycle, assert req_ready for the winner only (1 cycle). Latch a, b, sel and id; load alu_* from the latched values; go to ISSUE.
- If no request is valid, stay in IDLE.

ISSUE (1 cycle):
- The ALU samples the operands on this edge.
- Clear the wait counter; go to WAIT.

WAIT:
- The counter increments every cycle.
- If alu_complete == 1: capture alu_out into resp_data, set resp_err = 0, go to RESP.
- Else, when the counter reaches TIMEOUT: set resp_data = all-ones, resp_err = 1, go to RESP.
- A divide-by-zero (sel 5'b00011, b == 0) therefore ends in timeout by design.
- alu_* are held stable throughout WAIT.

RESP:
- resp_valid = 1; resp_id, resp_data, resp_zero and resp_err are held stable until resp_ready is sampled high.
- On that edge: resp_valid drops, alu_sel returns to IDLE_SEL, rr pointer = (winner + 1) mod NUM_REQ, go to IDLE.
- New grants are not possible until the next IDLE cycle. Minimum issue-to-issue spacing is 4 cycles, which guarantees IDLE_SEL executes at least once and clears the ALU's sticky complete flag.

Latency:
- A request accepted at cycle t gives resp_valid at t+3 in the best case (IDLE, ISSUE, WAIT with complete high on the first WAIT cycle).
- Timeout case: resp_valid at t+2+TIMEOUT.

Boundary conditions:
- req_valid dropping after grant has no effect; operands are already latched.
- A requester that is not granted must hold req_valid and its operands until it sees req_ready.
- All requesters valid: strict rotation, so each requester is served once per NUM_REQ operations.
- rr pointer wraps from NUM_REQ-1 to 0.
- Reset in any state: returns to IDLE on the next edge and drops resp_valid. A response still in flight is lost, with no error indication.
- resp_ready high while resp_valid is low is ignored.

Decomposition:
- Shared package alu_pkg holds the ALU opcode localparams (ADD 5'b00000 … WORD 5'b10100, IDLE 5'b11111), the state encoding (IDLE/ISSUE/WAIT/RESP) and DATA_W.
- One natural sub-module: rr_arbiter (parameter N; inputs req[N], ptr; outputs a one-hot grant and the grant index). It is reused by the CGRA interconnect.

Test Plan:
1. Single request: req 0, a=5, b=7, sel=ADD → req_ready[0] pulses; resp at +3 cycles with id=0, data=12, zero=0, err=0.
2. Zero flag: req 2, a=9, b=9, sel=SUB → data=0, zero=1, id=2.
3. Round-robin fairness: all 4 requests valid continuously with resp_ready tied high → grant order 0,1,2,3,0; no requester is granted twice before every other valid one is served.
4. Divide by zero: a=10, b=0, sel=DIV → resp after 2+TIMEOUT cycles with data=32'hFFFFFFFF, err=1. The next request (ADD 1+1) returns 2 with err=0, showing the complete flag was cleared.
5. Backpressure: resp_ready held low for 5 cycles → resp_valid and resp_data stable; no new req_ready while stalled; release → IDLE, then the next grant.
6. Reset mid-WAIT: assert reset during WAIT of a MUL → the next cycle shows busy=0, resp_valid=0 and alu_sel=5'b11111; a following request completes normally.
